partition_mmu: RTL
==================

# partition_mmu

Parametrised, pipelined memory management unit for the Thiele CPU. It translates module-tagged virtual addresses to physical addresses using a per-module page table, a fully associative TLB and per-module permissions, with valid/ready handshakes on the CPU, config and memory sides. It sits between the CPU load/store path and external memory, and replaces the single-cycle combinational MMU.

## Interface
- NUM_MODULES, 64: partition count; MOD_BITS = clog2(NUM_MODULES).
- PAGES_PER_MODULE, 256: page-table entries per module; PG_BITS = clog2(PAGES_PER_MODULE).
- TLB_ENTRIES, 8: TLB depth, ≥2.
- ADDR_W, 32: virtual/physical width; OFF_BITS = ADDR_W−MOD_BITS−PG_BITS; FRAME_W = ADDR_W−OFF_BITS.
- clk in 1: sole clock, rising edge.
- rst_n in 1: reset, synchronous, active-low.
- req_valid/req_ready in/out 1: CPU request handshake.
- req_addr in ADDR_W: {module, page, offset}, MSB first.
- req_we in 1; req_wdata in 32; req_module in MOD_BITS: issuing partition.
- rsp_valid/rsp_ready out/in 1: response handshake; rsp_rdata out 32; rsp_error out 32.
- cfg_valid/cfg_ready in/out 1; cfg_op in 2 (0 MAP, 1 UNMAP, 2 SET_PERM, 3 FLUSH); cfg_module in MOD_BITS; cfg_page in PG_BITS; cfg_data in FRAME_W (frame number, or perms in bits[2:0]).
- mem_en out 1, mem_ready in 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 32, mem_rdata in 32.
- stat_hits, stat_misses, stat_faults out 32: saturating counters.

## Operation
- Perms per module: bit0 read, bit1 write, bit2 shared (other modules may access). perms==0 means the module does not exist.
- Reset: all perms = 3'b011; all pages invalid; TLB empty; round-robin pointer = 0; counters = 0.
- FSM IDLE → LOOKUP → (WALK) → MEM → RESP → IDLE. Faults go LOOKUP/WALK → RESP, with no memory access.
- IDLE: cfg_ready = 1. req_ready = !cfg_valid. Config wins when both requests are valid. Requests are captured on handshake.
- LOOKUP: compare (module, page) against all valid TLB entries. Hit → stat_hits++, then check. Miss → stat_misses++, go to WALK.
- WALK: read page-table entry. If valid, fill the TLB slot at the round-robin pointer and increment the pointer mod TLB_ENTRIES. Then check.
- Check order, first failure wins:
  - module index ≥ NUM_MODULES or perms==0 → 0x1001.
  - page ≥ PAGES_PER_MODULE → 0x1003.
  - module ≠ req_module and !shared → 0x1002.
  - page invalid → 0x1004 (no TLB fill).
  - read without bit0, or write without bit1 → 0x1002.
  - otherwise the error is 0x0.
  - Any nonzero error → stat_faults++.
- Translation: physical = {frame, offset}.
- MEM: mem_en = 1, with mem_addr/mem_we/mem_wdata held stable until the cycle mem_ready = 1. The read result is captured from mem_rdata on that cycle.
- RESP: rsp_valid held with stable data until rsp_ready. rsp_rdata = 0 for writes and faults.
- Config ops complete in one IDLE cycle:
  - MAP: write frame and set valid.
  - UNMAP: clear valid.
  - SET_PERM: write perms.
  - FLUSH: clear all TLB valid bits.
  - MAP, UNMAP and SET_PERM also invalidate every TLB entry matching the module (and the page, for MAP/UNMAP).
- Counters saturate at 0xFFFF_FFFF.

## Timing
- Reset values: req_ready = 1, cfg_ready = 1, rsp_valid = 0, mem_en = 0, mem_we = 0, mem_addr = 0, rsp_error = 0, rsp_rdata = 0.
- Latency with request accepted at cycle 0:
  - TLB hit: mem_en at cycle 2; rsp_valid at cycle 3 if mem_ready is already high.
  - TLB miss: each of these is one cycle later.
  - Fault on hit: rsp_valid at cycle 2. Fault on miss: rsp_valid at cycle 3.
- One outstanding request; req_ready = 0 outside IDLE. Config is accepted only in IDLE.
- A TLB fill in WALK is visible to the next request's LOOKUP.
- mem_we and mem_en are never asserted for a faulting request.
- rst_n low mid-operation: on the next edge the FSM goes to IDLE, and mem_en and rsp_valid drop. Any in-flight response is discarded; tables are re-initialised.

## Test plan
- Hit path:
  - MAP module 3, page 5, frame 0x0C1.
  - Read req_module = 3, addr = {3,5,0x00ABC}: miss, mem_addr = {0x0C1,0x00ABC}, stat_misses = 1.
  - Repeat the read: hit, rsp_valid one cycle earlier, stat_hits = 1.
- Faults:
  - Unmapped page → 0x1004.
  - SET_PERM module 7 to 0, then access module 7 → 0x1001.
  - SET_PERM to 3'b001, then write → 0x1002.
  - Module 2 accessing module 3 (not shared) → 0x1002; after setting shared → 0x0.
  - In every case mem_en stays 0.
- TLB replacement: map and access TLB_ENTRIES+1 distinct pages, then re-access the first page → miss (slot 0 was evicted).
- Invalidation:
  - UNMAP a page cached in the TLB, then access it → 0x1004, not a stale hit.
  - FLUSH, then re-access a still-mapped page → miss.
- Backpressure:
  - Hold mem_ready = 0 for 4 cycles → mem_addr stable, then rsp_rdata = mem_rdata.
  - Hold rsp_ready = 0 → rsp_valid and rsp_rdata stay held, and req_ready = 0.
  - Assert cfg_valid and req_valid together in IDLE → cfg is accepted first.
- Reset: pull rst_n low during MEM → next cycle mem_en = 0, rsp_valid = 0; after release a previously mapped page faults 0x1004.

Source files
------------

// File: rtl/partition_mmu.sv
// Partition MMU: translates {module, page, offset} virtual addresses through a per-module
// page table and a round-robin fully associative TLB, then performs one memory access.
module partition_mmu #(
  parameter int NUM_MODULES      = 64,
  parameter int PAGES_PER_MODULE = 256,
  parameter int TLB_ENTRIES      = 8,
  parameter int ADDR_W           = 32,
  localparam int MOD_BITS = $clog2(NUM_MODULES),
  localparam int PG_BITS  = $clog2(PAGES_PER_MODULE),
  localparam int OFF_BITS = ADDR_W - MOD_BITS - PG_BITS,
  localparam int FRAME_W  = ADDR_W - OFF_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [31:0]         req_wdata,
  input  logic [MOD_BITS-1:0] req_module,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic [31:0]         rsp_error,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_op,
  input  logic [MOD_BITS-1:0] cfg_module,
  input  logic [PG_BITS-1:0]  cfg_page,
  input  logic [FRAME_W-1:0]  cfg_data,
  output logic                mem_en,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
  output logic [31:0]         stat_faults
);

  localparam int RR_BITS  = $clog2(TLB_ENTRIES);
  localparam int IDX_BITS = MOD_BITS + PG_BITS;
  localparam int PT_DEPTH = NUM_MODULES * PAGES_PER_MODULE;

  localparam logic [RR_BITS-1:0]  RR_LAST   = RR_BITS'(TLB_ENTRIES - 1);
  localparam logic [MOD_BITS:0]   NUM_MOD_L = (MOD_BITS + 1)'(NUM_MODULES);
  localparam logic [PG_BITS:0]    NUM_PG_L  = (PG_BITS + 1)'(PAGES_PER_MODULE);

  localparam logic [1:0] OP_MAP   = 2'd0;
  localparam logic [1:0] OP_UNMAP = 2'd1;
  localparam logic [1:0] OP_PERM  = 2'd2;
  localparam logic [1:0] OP_FLUSH = 2'd3;

  localparam logic [31:0] ERR_NONE    = 32'h0000_0000;
  localparam logic [31:0] ERR_NOMOD   = 32'h0000_1001;
  localparam logic [31:0] ERR_DENIED  = 32'h0000_1002;
  localparam logic [31:0] ERR_BADPAGE = 32'h0000_1003;
  localparam logic [31:0] ERR_UNMAP   = 32'h0000_1004;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WALK,
    S_MEM,
    S_RESP
  } state_t;

  state_t state;

  // Captured request (stage 0)
  logic [MOD_BITS-1:0] mod_p0;
  logic [PG_BITS-1:0]  page_p0;
  logic [OFF_BITS-1:0] off_p0;
  logic                we_p0;
  logic [31:0]         wdata_p0;
  logic [MOD_BITS-1:0] src_p0;

  // Tables
  logic [NUM_MODULES-1:0][2:0] perms;
  logic [PT_DEPTH-1:0]         pt_valid;
  logic [FRAME_W-1:0]          pt_frame [PT_DEPTH];
  logic [TLB_ENTRIES-1:0]      tlb_vld;
  logic [MOD_BITS-1:0]         tlb_mod   [TLB_ENTRIES];
  logic [PG_BITS-1:0]          tlb_pg    [TLB_ENTRIES];
  logic [FRAME_W-1:0]          tlb_frame [TLB_ENTRIES];
  logic [RR_BITS-1:0]          rr;

  logic [IDX_BITS-1:0] pt_idx;
  logic [IDX_BITS-1:0] cfg_idx;
  logic                hit;
  logic [FRAME_W-1:0]  hit_frame;
  logic [2:0]          perm_cur;
  logic                pg_present;
  logic [FRAME_W-1:0]  frame_sel;
  logic [31:0]         err_cur;
  logic                check_now;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // First failing condition wins.
  function automatic logic [31:0] fault_code(input logic mod_bad, input logic page_bad,
                                             input logic foreign, input logic unmapped,
                                             input logic denied);
    if (mod_bad)  return ERR_NOMOD;
    if (page_bad) return ERR_BADPAGE;
    if (foreign)  return ERR_DENIED;
    if (unmapped) return ERR_UNMAP;
    if (denied)   return ERR_DENIED;
    return ERR_NONE;
  endfunction

  assign req_ready = (state == S_IDLE) && !cfg_valid;
  assign cfg_ready = (state == S_IDLE);
  assign mem_wdata = wdata_p0;
  assign pt_idx    = {mod_p0, page_p0};
  assign cfg_idx   = {cfg_module, cfg_page};
  assign perm_cur  = perms[mod_p0];
  assign check_now = ((state == S_LOOKUP) && hit) || (state == S_WALK);

  always_comb begin
    hit       = 1'b0;
    hit_frame = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (tlb_vld[i] && (tlb_mod[i] == mod_p0) && (tlb_pg[i] == page_p0)) begin
        hit       = 1'b1;
        hit_frame = tlb_frame[i];
      end
    end
  end

  always_comb begin
    pg_present = (state == S_LOOKUP) ? hit : pt_valid[pt_idx];
    frame_sel  = (state == S_LOOKUP) ? hit_frame : pt_frame[pt_idx];
    err_cur    = fault_code(({1'b0, mod_p0} >= NUM_MOD_L) || (perm_cur == 3'b000),
                            ({1'b0, page_p0} >= NUM_PG_L),
                            (mod_p0 != src_p0) && !perm_cur[2],
                            !pg_present,
                            we_p0 ? !perm_cur[1] : !perm_cur[0]);
  end

  // Datapath storage: request capture, page-table frames, TLB tags and frames
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      mod_p0   <= req_addr[ADDR_W-1 -: MOD_BITS];
      page_p0  <= req_addr[OFF_BITS +: PG_BITS];
      off_p0   <= req_addr[OFF_BITS-1:0];
      we_p0    <= req_we;
      wdata_p0 <= req_wdata;
      src_p0   <= req_module;
    end
    if (cfg_valid && cfg_ready && (cfg_op == OP_MAP))
      pt_frame[cfg_idx] <= cfg_data;
    if ((state == S_WALK) && pt_valid[pt_idx]) begin
      tlb_mod[rr]   <= mod_p0;
      tlb_pg[rr]    <= page_p0;
      tlb_frame[rr] <= pt_frame[pt_idx];
    end
  end

  // Control FSM, valid bits, permissions and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rsp_valid   <= 1'b0;
      rsp_error   <= '0;
      rsp_rdata   <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      perms       <= {NUM_MODULES{3'b011}};
      pt_valid    <= '0;
      tlb_vld     <= '0;
      rr          <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_faults <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            unique case (cfg_op)
              OP_MAP:   pt_valid[cfg_idx] <= 1'b1;
              OP_UNMAP: pt_valid[cfg_idx] <= 1'b0;
              OP_PERM:  perms[cfg_module] <= cfg_data[2:0];
              default:  tlb_vld <= '0;
            endcase
            // Drop cached translations that the table update makes stale.
            if (cfg_op != OP_FLUSH) begin
              for (int i = 0; i < TLB_ENTRIES; i++) begin
                if ((tlb_mod[i] == cfg_module) && ((cfg_op == OP_PERM) || (tlb_pg[i] == cfg_page)))
                  tlb_vld[i] <= 1'b0;
              end
            end
          end else if (req_valid) begin
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            stat_hits <= sat_inc(stat_hits);
          end else begin
            stat_misses <= sat_inc(stat_misses);
            state       <= S_WALK;
          end
        end
        S_WALK: begin
          if (pt_valid[pt_idx]) begin
            tlb_vld[rr] <= 1'b1;
            rr          <= (rr == RR_LAST) ? '0 : rr + 1'b1;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= ERR_NONE;
            rsp_rdata <= we_p0 ? '0 : mem_rdata;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Translation resolved: either fault straight to the response or issue the access
      if (check_now) begin
        if (err_cur != ERR_NONE) begin
          stat_faults <= sat_inc(stat_faults);
          rsp_error   <= err_cur;
          rsp_rdata   <= '0;
          rsp_valid   <= 1'b1;
          state       <= S_RESP;
        end else begin
          mem_en   <= 1'b1;
          mem_we   <= we_p0;
          mem_addr <= {frame_sel, off_p0};
          state    <= S_MEM;
        end
      end
    end
  end

endmodule
